bus_master_if: RTL and testbench
================================

# bus_master_if

Initiator-side bus interface that lets one core (CPU fetch/data port, DMA) perform single-word accesses on the shared 4-master/8-slave bus through `bus_top`. It takes a one-cycle core request, arbitrates for the bus with `req_n`/`grnt_n`, and issues exactly one address strobe. It then waits for the addressed slave's `rdy_n`, returns read data, and releases the bus. A wait-state timeout prevents a missing or dead slave from hanging the core.

## Interface
Parameters:
- `TIMEOUT`, default 16: number of cycles spent in ACCESS without `bus_rdy_n` before the access is aborted with an error. Legal range is 2..255.

Ports:
- `clk` in 1: single clock; all logic is rising-edge.
- `reset` in 1: asynchronous reset, active-high.
- `core_as_n` in 1: core request strobe, active-low. Sampled only in IDLE.
- `core_rw` in 1: access direction, READ=1 and WRITE=0.
- `core_addr` in 30: word address. Bits [29:27] select the slave.
- `core_wr_data` in 32: write data.
- `core_rd_data` out 32: read data. Updated only by a successful read.
- `core_busy` out 1: high from request acceptance until the return to IDLE.
- `core_done` out 1: one-cycle pulse when the slave acknowledges.
- `core_err` out 1: one-cycle pulse on timeout.
- `bus_req_n` out 1: bus request to the arbiter, active-low.
- `bus_grnt_n` in 1: grant from the arbiter, active-low.
- `bus_addr` out 30: address to the bus.
- `bus_as_n` out 1: address strobe, active-low.
- `bus_rw` out 1: direction to the bus.
- `bus_wr_data` out 32: write data to the bus.
- `bus_rd_data` in 32: shared read data from the bus.
- `bus_rdy_n` in 1: shared ready from the bus, active-low.

## Operation
- All outputs are registered.
- Reset values (applied asynchronously): `bus_req_n`=1, `bus_as_n`=1, `bus_rw`=1, `bus_addr`=0, `bus_wr_data`=0, `core_rd_data`=0, `core_busy`=0, `core_done`=0, `core_err`=0. The FSM resets to IDLE and the timeout counter to 0.
- **IDLE**:
  - When `core_as_n`=0, latch `core_addr`, `core_rw` and `core_wr_data` into `bus_addr`, `bus_rw` and `bus_wr_data`.
  - Drive `bus_req_n`=0 and `core_busy`=1, then go to REQ.
- **REQ**:
  - Hold `bus_req_n`=0.
  - On sampling `bus_grnt_n`=0, drive `bus_as_n`=0, clear the counter and go to ACCESS.
  - `bus_rdy_n` is ignored in REQ, because it may belong to another master's transfer.
- **ACCESS**:
  - `bus_as_n` is low for the first ACCESS cycle only, then high.
  - `bus_addr`, `bus_rw` and `bus_wr_data` stay stable for the whole ACCESS state.
  - On sampling `bus_rdy_n`=0:
    - if `bus_rw`=READ, capture `bus_rd_data` into `core_rd_data`;
    - pulse `core_done`;
    - drive `bus_req_n`=1 and `core_busy`=0;
    - go to IDLE.
  - Otherwise, increment the counter. When the counter reaches `TIMEOUT`-1 without ready, pulse `core_err`, release the request and busy, go to IDLE, and leave `core_rd_data` unchanged.
- Boundary cases:
  - Ready and timeout on the same edge: ready wins, so `core_done` pulses and `core_err` does not.
  - `core_as_n` while busy is ignored. The core must hold off until `core_busy`=0. A strobe sampled on the same edge as the return to IDLE is also ignored, because IDLE samples from the next edge.
  - Grant deasserted while in REQ: stay in REQ.
  - Grant deasserted while in ACCESS: ignored; the timeout covers it.
  - Reset mid-access: all outputs immediately return to their reset values, so the bus request drops and the arbiter reclaims the bus.

## Timing
- For the edges below, E0 is the edge that samples `core_as_n`=0.
- Request: `bus_req_n` goes low after E0.
- Grant: the arbiter's grant is visible after E1, and the FSM samples it at E2.
- Strobe: `bus_as_n` is low between E2 and E3.
- Zero-wait slave: ready low in the strobe cycle is sampled at E3. `core_done` and the read data are valid after E3, and `bus_req_n` is high after E3. Best-case latency is 4 edges.
- Each slave wait state adds one cycle.
- Timeout: `core_err` is asserted after the `TIMEOUT`-th ACCESS edge.
- Back-to-back requests: the next request can be accepted at E4, one idle cycle minimum.

## Structure
- Shared bus defines header holds:
  - the state encodings `BUS_IF_IDLE`, `BUS_IF_REQ` and `BUS_IF_ACCESS`;
  - `BUS_IF_TIMEOUT_DEFAULT`;
  - `READ`, `WRITE`, `ENABLE_`, `DISABLE_`, and the `WORD_ADDR_BUS`/`WORD_DATA_BUS` widths, which already exist in the global defines.
- No sub-module. The FSM and an 8-bit timeout counter are inline.

## Test plan
- **Reset mid-access:** assert `reset` while in ACCESS → `bus_req_n`=1, `bus_as_n`=1, `core_busy`=0 immediately, and the FSM is in IDLE.
- **Write, zero-wait:** `core_addr`=30'h1000_0000, `core_wr_data`=32'h1234, `core_rw`=WRITE. With an immediate grant and slave `rdy_n`=0 in the strobe cycle → `bus_as_n` low for exactly 1 cycle with `s_addr`=30'h1000_0000 and `s_wr_data`=32'h1234, and `core_done` at E3.
- **Read, 2 wait states:** read 30'h3F00_0000, with s7 returning 32'h5678 and asserting ready 2 cycles after the strobe → `core_rd_data`=32'h5678 and `core_done` at E5.
- **Contention:** a second master holds the grant for 5 cycles → the block stays in REQ with `bus_as_n`=1, ignores s7's ready during that time, then strobes 1 edge after its grant is sampled.
- **Timeout:** `TIMEOUT`=4 and no ready → `core_err` pulses once at the 4th ACCESS edge, `core_rd_data` is unchanged, and `bus_req_n` returns to 1.
- **Ready at the timeout edge:** ready arrives exactly on the timeout edge → `core_done`=1 and `core_err`=0. A `core_as_n` pulse during busy produces no second access.

Source files
------------

// File: rtl/bus_master_if_pkg.sv
// Shared bus definitions: widths, direction/enable encodings and the
// initiator FSM state encoding used by bus_master_if.
package bus_master_if_pkg;

    localparam int WORD_ADDR_BUS = 30;
    localparam int WORD_DATA_BUS = 32;

    localparam logic READ     = 1'b1;
    localparam logic WRITE    = 1'b0;
    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;

    localparam int BUS_IF_TIMEOUT_DEFAULT = 16;
    localparam int BUS_IF_CNT_W           = 8;

    typedef enum logic [1:0] {
        BUS_IF_IDLE   = 2'd0,
        BUS_IF_REQ    = 2'd1,
        BUS_IF_ACCESS = 2'd2
    } bus_if_state_e;

endpackage

// File: rtl/bus_master_if.sv
// Initiator-side bus interface: one core access at a time, arbitrated with
// req_n/grnt_n, a single address strobe, and a wait-state timeout.
module bus_master_if
    import bus_master_if_pkg::*;
#(
    parameter int TIMEOUT = BUS_IF_TIMEOUT_DEFAULT
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     core_as_n,
    input  logic                     core_rw,
    input  logic [WORD_ADDR_BUS-1:0] core_addr,
    input  logic [WORD_DATA_BUS-1:0] core_wr_data,
    output logic [WORD_DATA_BUS-1:0] core_rd_data,
    output logic                     core_busy,
    output logic                     core_done,
    output logic                     core_err,
    output logic                     bus_req_n,
    input  logic                     bus_grnt_n,
    output logic [WORD_ADDR_BUS-1:0] bus_addr,
    output logic                     bus_as_n,
    output logic                     bus_rw,
    output logic [WORD_DATA_BUS-1:0] bus_wr_data,
    input  logic [WORD_DATA_BUS-1:0] bus_rd_data,
    input  logic                     bus_rdy_n,
    output logic [1:0]               dbg_state
);

    localparam logic [BUS_IF_CNT_W-1:0] TO_LAST = BUS_IF_CNT_W'(TIMEOUT - 1);

    bus_if_state_e             state_q;
    logic [BUS_IF_CNT_W-1:0]   cnt_q;
    logic [BUS_IF_CNT_W-1:0]   cnt_d;
    logic                      timeout_hit;
    logic [WORD_DATA_BUS-1:0]  rd_data_q;
    logic                      busy_q, done_q, err_q;
    logic                      req_n_q, as_n_q, rw_q;
    logic [WORD_ADDR_BUS-1:0]  addr_q;
    logic [WORD_DATA_BUS-1:0]  wr_data_q;

    always_comb begin
        cnt_d       = cnt_q + 1'b1;
        timeout_hit = (cnt_q == TO_LAST);
    end

    // Core side: a one-cycle low core_as_n is taken only in IDLE; busy then
    // covers the whole access and done/err are single-cycle completion pulses.
    // Bus side: request held low until completion; the strobe lasts exactly
    // the first ACCESS cycle and rdy_n is only meaningful once we own the bus.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= BUS_IF_IDLE;
            cnt_q     <= '0;
            rd_data_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            req_n_q   <= DISABLE_;
            as_n_q    <= DISABLE_;
            rw_q      <= READ;
            addr_q    <= '0;
            wr_data_q <= '0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                BUS_IF_IDLE: begin
                    if (core_as_n == ENABLE_) begin
                        addr_q    <= core_addr;
                        rw_q      <= core_rw;
                        wr_data_q <= core_wr_data;
                        req_n_q   <= ENABLE_;
                        busy_q    <= 1'b1;
                        state_q   <= BUS_IF_REQ;
                    end
                end
                BUS_IF_REQ: begin
                    if (bus_grnt_n == ENABLE_) begin
                        as_n_q  <= ENABLE_;
                        cnt_q   <= '0;
                        state_q <= BUS_IF_ACCESS;
                    end
                end
                BUS_IF_ACCESS: begin
                    as_n_q <= DISABLE_;
                    // Ready is checked first so it wins over a coincident timeout.
                    if (bus_rdy_n == ENABLE_) begin
                        if (rw_q == READ) begin
                            rd_data_q <= bus_rd_data;
                        end
                        done_q  <= 1'b1;
                        req_n_q <= DISABLE_;
                        busy_q  <= 1'b0;
                        state_q <= BUS_IF_IDLE;
                    end else if (timeout_hit) begin
                        err_q   <= 1'b1;
                        req_n_q <= DISABLE_;
                        busy_q  <= 1'b0;
                        state_q <= BUS_IF_IDLE;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                default: state_q <= BUS_IF_IDLE;
            endcase
        end
    end

    assign core_rd_data = rd_data_q;
    assign core_busy    = busy_q;
    assign core_done    = done_q;
    assign core_err     = err_q;
    assign bus_req_n    = req_n_q;
    assign bus_as_n     = as_n_q;
    assign bus_rw       = rw_q;
    assign bus_addr     = addr_q;
    assign bus_wr_data  = wr_data_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_bus_master_if.sv
// Bench for bus_master_if: acts as arbiter and slave, predicting each access
// outcome from grant delay, wait states and the timeout limit.
module tb_bus_master_if;
    import bus_master_if_pkg::*;

    localparam int TO = 4;

    logic        clk;
    logic        reset;
    logic        core_as_n;
    logic        core_rw;
    logic [29:0] core_addr;
    logic [31:0] core_wr_data;
    logic [31:0] core_rd_data;
    logic        core_busy;
    logic        core_done;
    logic        core_err;
    logic        bus_req_n;
    logic        bus_grnt_n;
    logic [29:0] bus_addr;
    logic        bus_as_n;
    logic        bus_rw;
    logic [31:0] bus_wr_data;
    logic [31:0] bus_rd_data;
    logic        bus_rdy_n;
    logic [1:0]  dbg_state;

    int          checks;
    int          errors;
    logic [31:0] model_rd;

    bus_master_if #(.TIMEOUT(TO)) dut (
        .clk          (clk),
        .reset        (reset),
        .core_as_n    (core_as_n),
        .core_rw      (core_rw),
        .core_addr    (core_addr),
        .core_wr_data (core_wr_data),
        .core_rd_data (core_rd_data),
        .core_busy    (core_busy),
        .core_done    (core_done),
        .core_err     (core_err),
        .bus_req_n    (bus_req_n),
        .bus_grnt_n   (bus_grnt_n),
        .bus_addr     (bus_addr),
        .bus_as_n     (bus_as_n),
        .bus_rw       (bus_rw),
        .bus_wr_data  (bus_wr_data),
        .bus_rd_data  (bus_rd_data),
        .bus_rdy_n    (bus_rdy_n),
        .dbg_state    (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One full access. gdel: extra cycles the arbiter withholds the grant
    // beyond its one-cycle registered latency. waits: slave wait states.
    task automatic run_txn(input logic rw, input logic [29:0] addr,
                           input logic [31:0] wd, input logic [31:0] rd,
                           input int gdel, input int waits, input bit stray);
        bit ok;
        int last;
        ok   = (waits + 1 <= TO);
        last = ok ? waits + 1 : TO;
        @(negedge clk);
        core_as_n = 1'b0; core_rw = rw; core_addr = addr; core_wr_data = wd;
        @(negedge clk);
        core_as_n = 1'b1; core_rw = 1'($urandom);
        core_addr = 30'($urandom); core_wr_data = $urandom;
        checks++;
        if (bus_req_n !== 1'b0 || core_busy !== 1'b1 || bus_as_n !== 1'b1)
            begin errors++; $display("FAIL accept: req_n=%b busy=%b as_n=%b exp 0 1 1", bus_req_n, core_busy, bus_as_n); end
        for (int i = 0; i < gdel + 1; i++) begin
            bus_rdy_n = 1'($urandom_range(0, 1));
            bus_rd_data = $urandom;
            core_as_n = stray ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            checks++;
            if (bus_as_n !== 1'b1 || bus_req_n !== 1'b0 || core_busy !== 1'b1 || core_done !== 1'b0 || core_rd_data !== model_rd)
                begin errors++; $display("FAIL req_hold[%0d]: as_n=%b req_n=%b busy=%b done=%b rd=%h exp 1 0 1 0 %h", i, bus_as_n, bus_req_n, core_busy, core_done, core_rd_data, model_rd); end
        end
        bus_grnt_n = 1'b0;
        bus_rdy_n = 1'b1;
        core_as_n = stray ? 1'($urandom_range(0, 1)) : 1'b1;
        @(negedge clk);
        checks++;
        if (bus_as_n !== 1'b0 || bus_addr !== addr || bus_rw !== rw || bus_wr_data !== wd)
            begin errors++; $display("FAIL strobe: as_n=%b addr=%h rw=%b wd=%h exp 0 %h %b %h", bus_as_n, bus_addr, bus_rw, bus_wr_data, addr, rw, wd); end
        for (int k = 1; k <= last; k++) begin
            bus_rdy_n   = (k == waits + 1) ? 1'b0 : 1'b1;
            bus_rd_data = (k == waits + 1) ? rd : $urandom;
            bus_grnt_n  = 1'($urandom_range(0, 1));
            core_as_n   = stray ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            checks++;
            if (k == last) begin
                if (ok && rw == READ) model_rd = rd;
                if (core_done !== ok || core_err !== !ok || core_busy !== 1'b0 || bus_req_n !== 1'b1 || bus_as_n !== 1'b1 || core_rd_data !== model_rd)
                    begin errors++; $display("FAIL finish: done=%b err=%b busy=%b req_n=%b as_n=%b rd=%h exp %b %b 0 1 1 %h", core_done, core_err, core_busy, bus_req_n, bus_as_n, core_rd_data, ok, !ok, model_rd); end
            end else begin
                if (core_done !== 1'b0 || core_err !== 1'b0 || core_busy !== 1'b1 || bus_req_n !== 1'b0 || bus_as_n !== 1'b1 ||
                    bus_addr !== addr || bus_rw !== rw || bus_wr_data !== wd || core_rd_data !== model_rd)
                    begin errors++; $display("FAIL access[%0d]: done=%b err=%b busy=%b req_n=%b as_n=%b addr=%h rd=%h exp 0 0 1 0 1 %h %h", k, core_done, core_err, core_busy, bus_req_n, bus_as_n, bus_addr, core_rd_data, addr, model_rd); end
            end
        end
        core_as_n = 1'b1; bus_rdy_n = 1'b1; bus_grnt_n = 1'b1;
        @(negedge clk);
        checks++;
        if (core_done !== 1'b0 || core_err !== 1'b0 || core_busy !== 1'b0 || bus_req_n !== 1'b1 || dbg_state !== BUS_IF_IDLE)
            begin errors++; $display("FAIL idle_after: done=%b err=%b busy=%b req_n=%b state=%0d exp 0 0 0 1 %0d", core_done, core_err, core_busy, bus_req_n, dbg_state, BUS_IF_IDLE); end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        core_as_n = 1'b1; core_rw = 1'b0; core_addr = '0; core_wr_data = '0;
        bus_grnt_n = 1'b1; bus_rd_data = '0; bus_rdy_n = 1'b1;
        model_rd = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (bus_req_n !== 1'b1 || bus_as_n !== 1'b1 || bus_rw !== 1'b1 || bus_addr !== 30'h0 || bus_wr_data !== 32'h0 ||
            core_rd_data !== 32'h0 || core_busy !== 1'b0 || core_done !== 1'b0 || core_err !== 1'b0 || dbg_state !== BUS_IF_IDLE)
            begin errors++; $display("FAIL reset_values: req_n=%b as_n=%b rw=%b addr=%h wd=%h rd=%h busy=%b done=%b err=%b state=%0d", bus_req_n, bus_as_n, bus_rw, bus_addr, bus_wr_data, core_rd_data, core_busy, core_done, core_err, dbg_state); end
        reset = 1'b0;
    endtask

    task automatic test_write_zero_wait();
        run_txn(WRITE, 30'h1000_0000, 32'h1234, 32'hDEAD_BEEF, 0, 0, 1'b0);
    endtask

    task automatic test_read_two_waits();
        run_txn(READ, 30'h3F00_0000, 32'h0, 32'h5678, 0, 2, 1'b0);
    endtask

    task automatic test_contention();
        run_txn(READ, 30'h3800_0010, 32'h0, 32'hA5A5_0001, 5, 1, 1'b0);
    endtask

    task automatic test_timeout();
        run_txn(READ, 30'h2000_0004, 32'h0, 32'hFFFF_0000, 1, TO + 2, 1'b0);
    endtask

    task automatic test_ready_at_timeout();
        run_txn(READ, 30'h0800_0040, 32'h0, 32'h0BAD_CAFE, 0, TO - 1, 1'b1);
    endtask

    task automatic test_reset_mid_access();
        @(negedge clk);
        core_as_n = 1'b0; core_rw = READ; core_addr = 30'h1234_5678; core_wr_data = 32'h1;
        @(negedge clk);
        core_as_n = 1'b1;
        @(negedge clk);
        bus_grnt_n = 1'b0;
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        model_rd = '0;
        checks++;
        if (bus_req_n !== 1'b1 || bus_as_n !== 1'b1 || core_busy !== 1'b0 || core_rd_data !== 32'h0 || dbg_state !== BUS_IF_IDLE)
            begin errors++; $display("FAIL reset_mid: req_n=%b as_n=%b busy=%b rd=%h state=%0d exp 1 1 0 0 %0d", bus_req_n, bus_as_n, core_busy, core_rd_data, dbg_state, BUS_IF_IDLE); end
        bus_grnt_n = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_random();
        logic        rw;
        logic [29:0] addr;
        logic [31:0] wd;
        logic [31:0] rd;
        for (int n = 0; n < 20; n++) begin
            rw   = 1'($urandom_range(0, 1));
            addr = 30'($urandom);
            wd   = $urandom;
            rd   = $urandom;
            run_txn(rw, addr, wd, rd, $urandom_range(0, 3), $urandom_range(0, TO + 1), 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_write_zero_wait();
        test_read_two_waits();
        test_contention();
        test_timeout();
        test_ready_at_timeout();
        test_reset_mid_access();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
